audio_playback_sequencer: RTL and testbench
===========================================

// Module: audio_playback_sequencer
// PURPOSE
//   Streams stereo PCM samples from a sample memory into the audio controller's
//   output FIFO: left_channel_audio_out, right_channel_audio_out and write_audio_out.
//   It sequences memory fetches, paces each write against audio_out_allowed,
//   and handles start, stop and loop. It sits between the WAV sample store and
//   the audio controller, sharing CLOCK_50 with it.
// PARAMETERS
//   AUDIO_DATA_WIDTH  16  bits per channel sample
//   ADDR_WIDTH        16  sample memory address width (one stereo word per address)
//   MEM_LATENCY       2   cycles from mem_rd to valid mem_rdata (legal range 1..7)
// PORTS
//   CLOCK_50                 in   1      system clock
//   reset_n                  in   1      asynchronous, active-low reset
//   start                    in   1      begin playback (accepted only in IDLE)
//   stop                     in   1      abort playback
//   loop_en                  in   1      1 = restart at start_addr after end_addr
//   start_addr               in   ADDR_WIDTH    first sample address
//   end_addr                 in   ADDR_WIDTH    last sample address (inclusive)
//   mem_addr                 out  ADDR_WIDTH    sample memory address
//   mem_rd                   out  1      memory read strobe, one cycle
//   mem_rdata                in   2*AUDIO_DATA_WIDTH  {left, right}; left is the upper half
//   audio_out_allowed        in   1      controller FIFO has space
//   clear_audio_out_memory   out  1      one-cycle FIFO flush at playback start
//   left_channel_audio_out   out  AUDIO_DATA_WIDTH  held sample, left channel
//   right_channel_audio_out  out  AUDIO_DATA_WIDTH  held sample, right channel
//   write_audio_out          out  1      one-cycle write strobe to the controller
//   busy                     out  1      1 whenever the state is not IDLE
//   done                     out  1      one-cycle pulse on a non-loop end of playback
// BEHAVIOUR
//   Reset values: all outputs 0; state IDLE; address pointer 0; latency counter 0.
//   Output registers: every output is registered; strobes are high for exactly one cycle.
//   States: IDLE, CLEAR, FETCH, WAIT_MEM, WAIT_ALLOWED, WRITE.
//   IDLE
//     - On start=1 and stop=0: latch start_addr, end_addr and loop_en; ptr <= start_addr;
//       go to CLEAR.
//     - start and stop high in the same cycle: stop wins, stay in IDLE.
//   CLEAR: clear_audio_out_memory=1 for this cycle; go to FETCH.
//   FETCH: mem_rd=1, mem_addr=ptr for one cycle; go to WAIT_MEM.
//   WAIT_MEM
//     - Capture mem_rdata exactly MEM_LATENCY cycles after the mem_rd cycle
//       into the left/right holding registers.
//     - Go to WAIT_ALLOWED.
//   WAIT_ALLOWED: wait while audio_out_allowed=0 (no timeout); go to WRITE when it is 1.
//   WRITE
//     - write_audio_out=1 for this single cycle; the audio data is stable during it
//       and until the next capture.
//     - ptr==end_addr and loop_en=1: ptr <= start_addr; go to FETCH.
//     - ptr==end_addr and loop_en=0: done=1 for one cycle; go to IDLE.
//     - Otherwise: ptr <= ptr+1, modulo 2^ADDR_WIDTH; go to FETCH.
//   Wrap-around: end_addr < start_addr is legal. ptr wraps through all-ones to 0
//     until it reaches end_addr.
//   Write spacing: there are at least 3+MEM_LATENCY cycles between write strobes.
//     This is sufficient given the controller's registered audio_out_allowed.
//   stop in any non-IDLE state
//     - Go to IDLE the next cycle; done is not pulsed.
//     - A write strobe already in WRITE still completes; no further writes are issued.
//     - A pending memory read is discarded.
//   Register changes only in IDLE: start is ignored while busy, and latched
//     addresses and loop_en cannot change mid-playback.
//   Reset: asserting reset_n low mid-operation clears all state immediately.
//     Outputs go to their reset values asynchronously.
// TESTING
//   1. start_addr=0x0010, end_addr=0x0013, loop_en=0, audio_out_allowed=1
//      -> clear pulse, then 4 writes of mem[0x10..0x13] in order, then one done pulse,
//         then busy=0.
//   2. Same run with loop_en=1 held for 10 writes
//      -> write sequence 10,11,12,13,10,11,...; done never pulses.
//   3. audio_out_allowed held 0 for 50 cycles after the first fetch
//      -> no write strobe during those cycles; the write occurs 1 cycle after allowed=1.
//   4. start_addr=0xFFFE, end_addr=0x0001
//      -> mem_addr sequence FFFE, FFFF, 0000, 0001, then done.
//   5. stop asserted in WAIT_ALLOWED
//      -> IDLE next cycle; zero further writes; done=0. Also: start and stop together
//         in IDLE -> busy stays 0.
//   6. reset_n pulsed low during WAIT_MEM
//      -> all outputs 0 asynchronously; a fresh start afterwards replays from start_addr.

Source files
------------

// File: rtl/audio_playback_sequencer.sv
// Streams stereo PCM words from sample memory into the audio controller FIFO.
// Handles start, stop, loop and address wrap; all outputs are registered.
module audio_playback_sequencer #(
    parameter int AUDIO_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH       = 16,
    parameter int MEM_LATENCY      = 2
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop_en,
    input  logic [ADDR_WIDTH-1:0]         start_addr,
    input  logic [ADDR_WIDTH-1:0]         end_addr,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_rd,
    input  logic [2*AUDIO_DATA_WIDTH-1:0] mem_rdata,
    input  logic                          audio_out_allowed,
    output logic                          clear_audio_out_memory,
    output logic [AUDIO_DATA_WIDTH-1:0]   left_channel_audio_out,
    output logic [AUDIO_DATA_WIDTH-1:0]   right_channel_audio_out,
    output logic                          write_audio_out,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT_MEM,
        S_WAIT_ALLOWED,
        S_WRITE
    } state_t;

    localparam logic [2:0]            LAT = 3'(MEM_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
    logic [ADDR_WIDTH-1:0] start_r, end_r;
    logic                  loop_r;
    logic [2:0]            lat_cnt, lat_nxt;
    logic                  latch, capture;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lat_nxt   = lat_cnt;
        latch     = 1'b0;
        capture   = 1'b0;
        if (state != S_IDLE && stop) begin
            state_nxt = S_IDLE;
            lat_nxt   = 3'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        latch     = 1'b1;
                        ptr_nxt   = start_addr;
                        state_nxt = S_CLEAR;
                    end
                end
                S_CLEAR: state_nxt = S_FETCH;
                S_FETCH: begin
                    lat_nxt   = 3'd1;
                    state_nxt = S_WAIT_MEM;
                end
                // lat_cnt counts cycles elapsed since the mem_rd cycle
                S_WAIT_MEM: begin
                    if (lat_cnt == LAT) begin
                        capture   = 1'b1;
                        lat_nxt   = 3'd0;
                        state_nxt = S_WAIT_ALLOWED;
                    end else begin
                        lat_nxt = lat_cnt + 3'd1;
                    end
                end
                S_WAIT_ALLOWED: begin
                    if (audio_out_allowed)
                        state_nxt = S_WRITE;
                end
                S_WRITE: begin
                    if (ptr == end_r) begin
                        if (loop_r) begin
                            ptr_nxt   = start_r;
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        ptr_nxt   = ptr + ONE;
                        state_nxt = S_FETCH;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            start_r <= '0;
            end_r   <= '0;
            loop_r  <= 1'b0;
            lat_cnt <= 3'd0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lat_cnt <= lat_nxt;
            if (latch) begin
                start_r <= start_addr;
                end_r   <= end_addr;
                loop_r  <= loop_en;
            end
        end
    end

    // Outputs decode the next state so each strobe lines up with its state
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr                <= '0;
            mem_rd                  <= 1'b0;
            clear_audio_out_memory  <= 1'b0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            write_audio_out         <= 1'b0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
        end else begin
            busy                   <= (state_nxt != S_IDLE);
            clear_audio_out_memory <= (state_nxt == S_CLEAR);
            mem_rd                 <= (state_nxt == S_FETCH);
            write_audio_out        <= (state_nxt == S_WRITE);
            done                   <= (state_nxt == S_WRITE) &&
                                      (ptr_nxt == end_r) && !loop_r;
            if (state_nxt == S_FETCH)
                mem_addr <= ptr_nxt;
            if (capture) begin
                left_channel_audio_out  <=
                    mem_rdata[2*AUDIO_DATA_WIDTH-1:AUDIO_DATA_WIDTH];
                right_channel_audio_out <=
                    mem_rdata[AUDIO_DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_audio_playback_sequencer.sv
// Directed bench for audio_playback_sequencer.
// Sample memory model returns data exactly MEM_LATENCY cycles after mem_rd.
module tb_audio_playback_sequencer;

    localparam int L = 2;

    logic        CLOCK_50;
    logic        reset_n;
    logic        start, stop, loop_en;
    logic [15:0] start_addr, end_addr;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        audio_out_allowed;
    logic        clear_audio_out_memory;
    logic [15:0] left_channel_audio_out, right_channel_audio_out;
    logic        write_audio_out, busy, done;

    audio_playback_sequencer #(
        .AUDIO_DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .MEM_LATENCY(L)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n(reset_n),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .start_addr(start_addr),
        .end_addr(end_addr),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_rdata(mem_rdata),
        .audio_out_allowed(audio_out_allowed),
        .clear_audio_out_memory(clear_audio_out_memory),
        .left_channel_audio_out(left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .write_audio_out(write_audio_out),
        .busy(busy),
        .done(done)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] f(input logic [15:0] a);
        return {a ^ 16'h5A00, ~a};
    endfunction

    logic [31:0] pipe [L];
    always @(posedge CLOCK_50) begin
        pipe[0] <= mem_rd ? f(mem_addr) : 32'hDEADBEEF;
        for (int i = 1; i < L; i++)
            pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[L-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] wq[$];
    logic [15:0] aq[$];
    int done_cnt, clr_cnt, last_wr, first_wr, min_gap;

    always @(posedge CLOCK_50) cyc++;

    always @(negedge CLOCK_50) begin
        if (write_audio_out === 1'b1) begin
            wq.push_back({left_channel_audio_out, right_channel_audio_out});
            if (last_wr >= 0 && cyc - last_wr < min_gap)
                min_gap = cyc - last_wr;
            if (first_wr < 0)
                first_wr = cyc;
            last_wr = cyc;
        end
        if (mem_rd === 1'b1) aq.push_back(mem_addr);
        if (done === 1'b1) done_cnt++;
        if (clear_audio_out_memory === 1'b1) clr_cnt++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        aq.delete();
        done_cnt = 0;
        clr_cnt  = 0;
        last_wr  = -1;
        first_wr = -1;
        min_gap  = 1000;
    endtask

    task automatic kick(input logic [15:0] sa, input logic [15:0] ea,
                        input logic lp);
        start_addr = sa;
        end_addr   = ea;
        loop_en    = lp;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        start_addr = 16'h0;
        end_addr   = 16'h0;
    endtask

    task automatic test_reset();
        logic [87:0] outs;
        reset_n = 1'b0;
        start = 0; stop = 0; loop_en = 0;
        start_addr = 0; end_addr = 0;
        audio_out_allowed = 0;
        clear_mon();
        repeat (3) tick();
        outs = {busy, mem_rd, mem_addr, clear_audio_out_memory,
                write_audio_out, done, left_channel_audio_out,
                right_channel_audio_out, 28'h0};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_pass();
        clear_mon();
        audio_out_allowed = 1;
        kick(16'h0010, 16'h0013, 1'b0);
        for (int n = 0; n < 200 && busy; n++) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_end_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (clr_cnt !== 1) begin
            n_fail++;
            $display("FAIL pass_clear: got %0d expected 1", clr_cnt);
        end
        n_checks++;
        if (wq.size() !== 4) begin
            n_fail++;
            $display("FAIL pass_nwrites: got %0d expected 4", wq.size());
        end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i] !== f(16'h0010 + 16'(i))) begin
                n_fail++;
                $display("FAIL pass_data%0d: got %h expected %h",
                         i, wq[i], f(16'h0010 + 16'(i)));
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL pass_done: got %0d expected 1", done_cnt);
        end
        n_checks++;
        if (min_gap !== 3 + L) begin
            n_fail++;
            $display("FAIL pass_gap: got %0d expected %0d", min_gap, 3 + L);
        end
    endtask

    task automatic test_loop();
        clear_mon();
        audio_out_allowed = 1;
        kick(16'h0010, 16'h0013, 1'b1);
        for (int n = 0; n < 400 && wq.size() < 10; n++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_stop_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (wq.size() < 10) begin
            n_fail++;
            $display("FAIL loop_nwrites: got %0d expected 10", wq.size());
        end
        for (int i = 0; i < 10 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i] !== f(16'h0010 + 16'(i % 4))) begin
                n_fail++;
                $display("FAIL loop_data%0d: got %h expected %h",
                         i, wq[i], f(16'h0010 + 16'(i % 4)));
            end
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL loop_done: got %0d expected 0", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int set_cyc;
        clear_mon();
        audio_out_allowed = 0;
        kick(16'h0020, 16'h0020, 1'b0);
        for (int n = 0; n < 20 && aq.size() == 0; n++) tick();
        repeat (50) tick();
        n_checks++;
        if (wq.size() !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got writes=%0d busy=%b expected 0/1",
                     wq.size(), busy);
        end
        audio_out_allowed = 1;
        set_cyc = cyc;
        for (int n = 0; n < 50 && busy; n++) tick();
        n_checks++;
        if (first_wr !== set_cyc + 1) begin
            n_fail++;
            $display("FAIL bp_latency: got cycle %0d expected %0d",
                     first_wr, set_cyc + 1);
        end
        n_checks++;
        if (wq.size() !== 1 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL bp_count: got writes=%0d done=%0d expected 1/1",
                     wq.size(), done_cnt);
        end
        n_checks++;
        if (wq.size() > 0 && wq[0] !== f(16'h0020)) begin
            n_fail++;
            $display("FAIL bp_data: got %h expected %h", wq[0], f(16'h0020));
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4];
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        clear_mon();
        audio_out_allowed = 1;
        kick(16'hFFFE, 16'h0001, 1'b0);
        for (int n = 0; n < 200 && busy; n++) tick();
        n_checks++;
        if (aq.size() !== 4 || wq.size() !== 4 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL wrap_count: got rd=%0d wr=%0d done=%0d expected 4/4/1",
                     aq.size(), wq.size(), done_cnt);
        end
        for (int i = 0; i < 4 && i < aq.size(); i++) begin
            n_checks++;
            if (aq[i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got %h expected %h",
                         i, aq[i], exp_a[i]);
            end
        end
        n_checks++;
        if (wq.size() == 4 && wq[2] !== f(16'h0000)) begin
            n_fail++;
            $display("FAIL wrap_data: got %h expected %h", wq[2], f(16'h0000));
        end
    endtask

    task automatic test_stop();
        clear_mon();
        audio_out_allowed = 0;
        kick(16'h0030, 16'h0033, 1'b0);
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_busy: got %b expected 0", busy);
        end
        audio_out_allowed = 1;
        repeat (20) tick();
        n_checks++;
        if (wq.size() !== 0 || done_cnt !== 0) begin
            n_fail++;
            $display("FAIL stop_quiet: got writes=%0d done=%0d expected 0/0",
                     wq.size(), done_cnt);
        end
        clear_mon();
        start_addr = 16'h0050;
        end_addr   = 16'h0051;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (busy !== 1'b0 || clr_cnt !== 0 || aq.size() !== 0) begin
            n_fail++;
            $display("FAIL start_stop: got busy=%b clr=%0d rd=%0d expected 0/0/0",
                     busy, clr_cnt, aq.size());
        end
    endtask

    task automatic test_async_reset();
        logic [87:0] outs;
        clear_mon();
        audio_out_allowed = 1;
        kick(16'h0040, 16'h0043, 1'b0);
        for (int n = 0; n < 20 && aq.size() == 0; n++) tick();
        n_checks++;
        if (busy !== 1'b1 || mem_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL arst_pre: got busy=%b addr=%h expected 1/0040",
                     busy, mem_addr);
        end
        #2 reset_n = 1'b0;
        #1;
        outs = {busy, mem_rd, mem_addr, clear_audio_out_memory,
                write_audio_out, done, left_channel_audio_out,
                right_channel_audio_out, 28'h0};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL arst_outputs: got %h expected 0", outs);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        clear_mon();
        kick(16'h0040, 16'h0043, 1'b0);
        for (int n = 0; n < 200 && busy; n++) tick();
        n_checks++;
        if (wq.size() !== 4 || done_cnt !== 1 ||
            aq.size() == 0 || aq[0] !== 16'h0040) begin
            n_fail++;
            $display("FAIL arst_replay: got wr=%0d done=%0d rd=%0d expected 4/1/from 0040",
                     wq.size(), done_cnt, aq.size());
        end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            n_checks++;
            if (wq[i] !== f(16'h0040 + 16'(i))) begin
                n_fail++;
                $display("FAIL arst_data%0d: got %h expected %h",
                         i, wq[i], f(16'h0040 + 16'(i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_loop();
        test_backpressure();
        test_wrap();
        test_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
